// File: rtl/root_controller.sv
// Root-FPGA stage controller: drives the decode handshake to all children,
// watches their busy/odd reports and sequences grow/merge, peel and release.
module root_controller #(
    parameter int CHILD_FPGA_COUNT        = 2,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int MAXIMUM_INITIAL_DELAY   = 3,
    parameter int MAXIMUM_BUSY_DELAY      = 1,
    parameter int QUIET_CYCLES            = 2,
    parameter int MAX_ITERATIONS          = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [CHILD_FPGA_COUNT-1:0]        busy_from_child,
    input  logic [CHILD_FPGA_COUNT-1:0]        odd_clusters_from_child,
    output logic                               decoding_start,
    output logic                               next_iteration,
    output logic [2:0]                         root_stage,
    output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    output logic [31:0]                        cycle_counter,
    output logic                               done,
    output logic                               timeout
);

    localparam int SETTLE_CYCLES  = MAXIMUM_INITIAL_DELAY + MAXIMUM_BUSY_DELAY + 2;
    localparam int RELEASE_CYCLES = MAXIMUM_BUSY_DELAY + 2;
    localparam int DMAX = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
    localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam int QW   = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam int ITW  = ITERATION_COUNTER_WIDTH;

    localparam logic [DW-1:0]  SETTLE_LAST  = DW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0]  RELEASE_LAST = DW'(RELEASE_CYCLES - 1);
    localparam logic [QW-1:0]  QUIET_LAST   = QW'(QUIET_CYCLES - 1);
    localparam logic [ITW-1:0] ITER_CAP     = ITW'(MAX_ITERATIONS);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_WAIT_QUIET = 3'd2,
        ST_PEEL_WAIT  = 3'd3,
        ST_RELEASE    = 3'd4
    } stage_e;

    stage_e                        state_q;
    logic [CHILD_FPGA_COUNT-1:0]   busy_q;
    logic [CHILD_FPGA_COUNT-1:0]   odd_q;
    logic [DW-1:0]                 delay_q;
    logic [QW-1:0]                 quiet_q;
    logic                          start_q;
    logic                          next_q;
    logic [ITW-1:0]                iter_q;
    logic [31:0]                   cycles_q;
    logic [31:0]                   cycles_d;
    logic                          done_q;
    logic                          timeout_q;
    logic                          any_busy;
    logic                          any_odd;

    // Saturating cycle increment and aggregated child reports.
    always_comb begin
        cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
        any_busy = |busy_q;
        any_odd  = |odd_q;
    end

    // Stage sequencer with registered handshake, counters and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= '0;
            odd_q     <= '0;
            delay_q   <= '0;
            quiet_q   <= '0;
            start_q   <= 1'b0;
            next_q    <= 1'b0;
            iter_q    <= '0;
            cycles_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            busy_q <= busy_from_child;
            odd_q  <= odd_clusters_from_child;
            done_q <= 1'b0;
            if (state_q != ST_IDLE) begin
                cycles_q <= cycles_d;
            end
            case (state_q)
                ST_IDLE: begin
                    start_q <= 1'b0;
                    next_q  <= 1'b0;
                    if (start) begin
                        start_q   <= 1'b1;
                        iter_q    <= ITW'(1);
                        cycles_q  <= 32'd1;
                        timeout_q <= 1'b0;
                        delay_q   <= '0;
                        state_q   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (delay_q == SETTLE_LAST) begin
                        quiet_q <= '0;
                        state_q <= ST_WAIT_QUIET;
                    end else begin
                        delay_q <= delay_q + 1'b1;
                    end
                end
                ST_WAIT_QUIET: begin
                    if (any_busy) begin
                        quiet_q <= '0;
                    end else if (quiet_q < QUIET_LAST) begin
                        quiet_q <= quiet_q + 1'b1;
                    end else if (any_odd && (iter_q < ITER_CAP)) begin
                        next_q  <= ~next_q;
                        iter_q  <= iter_q + 1'b1;
                        delay_q <= '0;
                        state_q <= ST_SETTLE;
                    end else begin
                        start_q   <= 1'b0;
                        timeout_q <= any_odd;
                        delay_q   <= '0;
                        state_q   <= ST_PEEL_WAIT;
                    end
                end
                ST_PEEL_WAIT: begin
                    if (delay_q == SETTLE_LAST) begin
                        next_q  <= 1'b1;
                        delay_q <= '0;
                        state_q <= ST_RELEASE;
                    end else begin
                        delay_q <= delay_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (delay_q == RELEASE_LAST) begin
                        next_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        delay_q <= delay_q + 1'b1;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    next_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign decoding_start    = start_q;
    assign next_iteration    = next_q;
    assign root_stage        = state_q;
    assign iteration_counter = iter_q;
    assign cycle_counter     = cycles_q;
    assign done              = done_q;
    assign timeout           = timeout_q;

endmodule

// File: tb/tb_root_controller.sv
// Bench for root_controller: phase-level behavioural model checked every
// cycle, plus hand-computed edge numbers and counter values.
module tb_root_controller;

    localparam int SETTLE = 3 + 1 + 2;
    localparam int REL    = 1 + 2;
    localparam int Q      = 2;
    localparam int MAXI   = 255;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] busy  = 2'b00;
    logic [1:0] odd   = 2'b00;

    logic        ds, ni, done, to;
    logic [2:0]  stage;
    logic [7:0]  iter;
    logic [31:0] cc;
    logic        ds3, ni3, done3, to3;
    logic [2:0]  stage3;
    logic [7:0]  iter3;
    logic [31:0] cc3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    root_controller dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .busy_from_child         (busy),
        .odd_clusters_from_child (odd),
        .decoding_start          (ds),
        .next_iteration          (ni),
        .root_stage              (stage),
        .iteration_counter       (iter),
        .cycle_counter           (cc),
        .done                    (done),
        .timeout                 (to)
    );

    root_controller #(.MAX_ITERATIONS(3)) dut3 (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .busy_from_child         (busy),
        .odd_clusters_from_child (odd),
        .decoding_start          (ds3),
        .next_iteration          (ni3),
        .root_stage              (stage3),
        .iteration_counter       (iter3),
        .cycle_counter           (cc3),
        .done                    (done3),
        .timeout                 (to3)
    );

    // Model: registered view of the children's reports
    logic mb, mo;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mb <= 1'b0;
            mo <= 1'b0;
        end else begin
            mb <= |busy;
            mo <= |odd;
        end
    end

    logic        e_ds, e_ni, e_done, e_to;
    logic [2:0]  e_stage;
    logic [7:0]  e_iter;
    logic [31:0] e_cc;

    task automatic m_clear();
        e_ds = 0; e_ni = 0; e_done = 0; e_to = 0;
        e_stage = 0; e_iter = 0; e_cc = 0;
    endtask

    task automatic m_tick(output bit ab);
        @(posedge clk);
        ab = reset;
        if (!ab && e_cc != 32'hFFFF_FFFF) e_cc = e_cc + 1;
    endtask

    // One decode as a sequence of phases
    task automatic m_decode();
        bit ab;
        int run;
        e_ds = 1; e_ni = 0; e_iter = 1; e_cc = 1;
        e_done = 0; e_to = 0; e_stage = 1;
        forever begin
            for (int i = 0; i < SETTLE; i++) begin
                m_tick(ab);
                if (ab) return;
            end
            e_stage = 2;
            run = 0;
            forever begin
                m_tick(ab);
                if (ab) return;
                run = mb ? 0 : run + 1;
                if (run == Q) break;
            end
            if (mo && e_iter < MAXI) begin
                e_ni = !e_ni;
                e_iter = e_iter + 1;
                e_stage = 1;
            end else begin
                e_ds = 0;
                e_to = mo;
                e_stage = 3;
                break;
            end
        end
        for (int i = 0; i < SETTLE; i++) begin
            m_tick(ab);
            if (ab) return;
        end
        e_ni = 1;
        e_stage = 4;
        for (int i = 0; i < REL; i++) begin
            m_tick(ab);
            if (ab) return;
        end
        e_ni = 0;
        e_done = 1;
        e_stage = 0;
    endtask

    initial begin : model
        m_clear();
        forever begin
            @(posedge clk);
            if (reset) begin
                m_clear();
            end else begin
                e_done = 0;
                if (start) m_decode();
            end
        end
    end

    // Per-cycle comparison against the model
    logic [46:0] got_v, exp_v;
    always @(negedge clk) begin
        got_v = {ds, ni, stage, iter, cc, done, to};
        exp_v = reset ? 47'd0 : {e_ds, e_ni, e_stage, e_iter, e_cc, e_done, e_to};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle t=%0t got ds=%b ni=%b st=%0d it=%0d cc=%0d dn=%b to=%b want %h",
                     $time, ds, ni, stage, iter, cc, done, to, exp_v);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [1:0] pick(input logic [1:0] v, input int k,
                                        input int lo, input int hi);
        return (k >= lo && k <= hi) ? v : 2'b00;
    endfunction

    // Start one decode; inputs sampled at edge k follow the given windows.
    task automatic go(input logic [1:0] oddv, input int olast,
                      input logic [1:0] busyv, input int bfirst, input int blast,
                      input int limit,
                      output int done_e, output int tog, output int ni_e,
                      output int dsf_e, output int tog3, output int done3_e,
                      output int dsf3_e);
        logic pni, pni3;
        done_e = -1; tog = 0; ni_e = -1; dsf_e = -1;
        tog3 = 0; done3_e = -1; dsf3_e = -1;
        pni = ni; pni3 = ni3;
        start = 1;
        odd  = pick(oddv, 0, 0, olast);
        busy = pick(busyv, 0, bfirst, blast);
        for (int e = 0; e < limit; e++) begin
            @(posedge clk);
            #2;
            start = 0;
            odd  = pick(oddv, e + 1, 0, olast);
            busy = pick(busyv, e + 1, bfirst, blast);
            if (ni != pni && ds) tog++;
            if (ni3 != pni3 && ds3) tog3++;
            pni = ni; pni3 = ni3;
            if (ni && !ds && ni_e < 0) ni_e = e;
            if (!ds && dsf_e < 0) dsf_e = e;
            if (!ds3 && dsf3_e < 0) dsf3_e = e;
            if (done3 && done3_e < 0) done3_e = e;
            if (done && done_e < 0) done_e = e;
            if (done_e >= 0 && done3_e >= 0) break;
        end
        odd = 2'b00;
        busy = 2'b00;
    endtask

    int d, t, nie, dsf, t3, d3, dsf3, seen;

    initial begin
        #1 reset = 1;
        idle(3);
        reset = 0;
        chk("reset_stage", stage, 0);
        chk("reset_iter", iter, 0);
        chk("reset_cc", cc, 0);
        chk("reset_hs", {ds, ni, done, to}, 0);
        idle(2);

        // Single iteration, children idle
        go(2'b00, -1, 2'b00, 1, 0, 200, d, t, nie, dsf, t3, d3, dsf3);
        chk("t1_done_edge", d, 17);
        chk("t1_ds_fall", dsf, 8);
        chk("t1_ni_rise", nie, 14);
        chk("t1_iter", iter, 1);
        chk("t1_cc", cc, 18);
        chk("t1_timeout", to, 0);
        chk("t1_toggles", t, 0);
        idle(1);
        chk("t1_done_pulse", done, 0);
        idle(2);

        // Odd clusters for the first iteration only
        go(2'b01, 8, 2'b00, 1, 0, 200, d, t, nie, dsf, t3, d3, dsf3);
        chk("t2_done_edge", d, 25);
        chk("t2_toggles", t, 1);
        chk("t2_iter", iter, 2);
        chk("t2_cc", cc, 26);
        idle(3);

        // Busy on child 1 sampled at edges 7..11
        go(2'b00, -1, 2'b10, 7, 11, 200, d, t, nie, dsf, t3, d3, dsf3);
        chk("t3_done_edge", d, 23);
        chk("t3_ds_fall", dsf, 14);
        chk("t3_iter", iter, 1);
        chk("t3_cc", cc, 24);
        idle(3);

        // Odd held: cap of 3 on dut3, cap of 255 on dut
        go(2'b11, 100000, 2'b00, 1, 0, 2200, d, t, nie, dsf, t3, d3, dsf3);
        chk("t4_cap3_toggles", t3, 2);
        chk("t4_cap3_ds_fall", dsf3, 24);
        chk("t4_cap3_done_edge", d3, 33);
        chk("t4_cap3_iter", iter3, 3);
        chk("t4_cap3_timeout", to3, 1);
        chk("t4_done_edge", d, 2049);
        chk("t4_toggles", t, 254);
        chk("t4_iter", iter, 255);
        chk("t4_timeout", to, 1);
        chk("t4_cc", cc, 2050);
        idle(3);

        // Reset during PEEL_WAIT
        start = 1;
        idle(1);
        start = 0;
        idle(10);
        chk("t5_in_peel", stage, 3);
        reset = 1;
        #1;
        chk("t5_rst_stage", stage, 0);
        chk("t5_rst_hs", {ds, ni, done, to}, 0);
        chk("t5_rst_iter", iter, 0);
        chk("t5_rst_cc", cc, 0);
        idle(2);
        reset = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (done) seen++;
        end
        chk("t5_no_done", seen, 0);
        go(2'b00, -1, 2'b00, 1, 0, 200, d, t, nie, dsf, t3, d3, dsf3);
        chk("t5_redo_done_edge", d, 17);
        chk("t5_redo_cc", cc, 18);
        idle(3);

        // Start held high across two decodes
        start = 1;
        d = -1;
        for (int e = 0; e < 200; e++) begin
            idle(1);
            if (done) begin
                d = e;
                break;
            end
        end
        chk("t6_first_done", d, 17);
        idle(1);
        start = 0;
        chk("t6_restart_ds", ds, 1);
        chk("t6_restart_iter", iter, 1);
        chk("t6_restart_cc", cc, 1);
        chk("t6_restart_done", done, 0);
        d = -1;
        for (int e = 1; e < 200; e++) begin
            idle(1);
            if (done) begin
                d = e;
                break;
            end
        end
        chk("t6_second_done", d, 17);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/root_controller.md
# root_controller

Parent-side stage controller for the multi-FPGA decoder. It drives the decode handshake that every child FPGA controller consumes, and aggregates the children's busy and odd-cluster reports. It decides when each grow/merge iteration has converged, either starts another iteration or moves the children to peeling, and reports total iterations and cycle count. It sits on the root FPGA, one instance per decoder, with one busy/odd pair per child link.

## Interface
- CHILD_FPGA_COUNT, 2, number of child FPGAs (width of the aggregate inputs)
- ITERATION_COUNTER_WIDTH, 8, width of iteration_counter
- MAXIMUM_INITIAL_DELAY, 3, cycles a child waits in merge/peeling before sampling handshake inputs
- MAXIMUM_BUSY_DELAY, 1, one-way link latency in cycles, either direction
- QUIET_CYCLES, 2, consecutive all-idle samples required to declare convergence (≥1)
- MAX_ITERATIONS, 255, iteration cap (≤ 2^ITERATION_COUNTER_WIDTH − 1)
- Derived: SETTLE_CYCLES = MAXIMUM_INITIAL_DELAY + MAXIMUM_BUSY_DELAY + 2; RELEASE_CYCLES = MAXIMUM_BUSY_DELAY + 2
- Clock/reset: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- start  in  1  request a decode; sampled only in IDLE
- busy_from_child  in  CHILD_FPGA_COUNT  per-child busy (child-registered)
- odd_clusters_from_child  in  CHILD_FPGA_COUNT  per-child odd-cluster flag
- decoding_start  out  1  level; high for the whole grow/merge phase
- next_iteration  out  1  toggles per new iteration; driven to level 1 to release peeling
- root_stage  out  3  IDLE=0, SETTLE=1, WAIT_QUIET=2, PEEL_WAIT=3, RELEASE=4
- iteration_counter  out  ITERATION_COUNTER_WIDTH  iterations of the current/last decode
- cycle_counter  out  32  cycles of the current/last decode
- done  out  1  one-cycle pulse at decode completion
- timeout  out  1  last decode hit MAX_ITERATIONS with odd clusters still present

## Operation
- Register inputs into busy_q and odd_q every cycle. Decisions use only the registered copies.
- The FSM uses delay_cnt and quiet_cnt.
- IDLE:
  - Drive decoding_start=0 and next_iteration=0.
  - On start=1: decoding_start←1, iteration_counter←1, cycle_counter←1, done←0, timeout←0, delay_cnt←0 → SETTLE.
- SETTLE:
  - Ignore busy/odd.
  - delay_cnt+1 each cycle; when delay_cnt==SETTLE_CYCLES−1 → WAIT_QUIET, quiet_cnt←0.
- WAIT_QUIET:
  - If |busy_q is high: quiet_cnt←0.
  - Else if quiet_cnt<QUIET_CYCLES−1: quiet_cnt+1.
  - Else decide, using odd_q from the same cycle:
    - |odd_q and iteration_counter<MAX_ITERATIONS: toggle next_iteration, iteration_counter+1, delay_cnt←0 → SETTLE.
    - Otherwise: decoding_start←0, timeout←|odd_q, delay_cnt←0 → PEEL_WAIT.
- PEEL_WAIT: count SETTLE_CYCLES as in SETTLE; on the final count, next_iteration←1, delay_cnt←0 → RELEASE.
- RELEASE:
  - Hold next_iteration=1 for RELEASE_CYCLES.
  - On the final count: next_iteration←0, done←1 → IDLE.
- done clears the following cycle.
- cycle_counter:
  - +1 every cycle the FSM is not in IDLE.
  - Saturates at 0xFFFFFFFF.
  - Holds its value in IDLE.
- iteration_counter and timeout hold in IDLE until the next accepted start.
- start outside IDLE is ignored; nothing queues.
- An undefined root_stage encoding → IDLE, with handshake outputs driven 0.

## Timing
- Reset (async assert) forces:
  - root_stage=IDLE
  - decoding_start=0, next_iteration=0
  - iteration_counter=0, cycle_counter=0
  - done=0, timeout=0
  - busy_q=0, odd_q=0, delay_cnt=0, quiet_cnt=0
- Reset mid-decode abandons the decode with no done pulse. Children see decoding_start=0 and next_iteration=0.
- All outputs are registered. Counting edge 0 as the one that samples start, decoding_start rises after edge 0.
- Converging decode with k iterations and immediately idle children: done is high after edge 9 + 8·k, i.e. edge 17 for k=1 at defaults.
- Busy rising in the same cycle quiet_cnt would complete: the counter resets and no decision is made.
- In the toggle-then-peel case, next_iteration may already be 1 entering RELEASE. It stays 1, which is legal; peeling requires level 1, not an edge.

## Test plan
- Defaults, start pulse at edge 0, all busy/odd low:
  - decoding_start high edges 0–8
  - next_iteration high edges 14–17
  - done high for one cycle after edge 17
  - iteration_counter=1, cycle_counter=18, timeout=0
- odd_clusters_from_child=2'b01 until the first toggle, then 0:
  - exactly one next_iteration toggle (after edge 8)
  - done after edge 25, iteration_counter=2
- busy_from_child[1] high for 5 cycles starting mid-WAIT_QUIET:
  - quiet_cnt restarts
  - decision occurs exactly QUIET_CYCLES samples after busy_q falls
  - done delayed accordingly
- MAX_ITERATIONS=3, odd held high:
  - 2 toggles, then decoding_start falls
  - iteration_counter=3, timeout=1, done still pulses
- Assert reset in PEEL_WAIT: all outputs return to reset values immediately, with no done. The next start then decodes normally.
- start held high through an entire decode: second decode begins the cycle after done deasserts. cycle_counter and iteration_counter restart at 1.
